regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, the register address width; there are 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 4, the number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2, the number of write (writeback) ports.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port rd_addr, input, NUM_RD*ADDR_W bits: packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data, output, NUM_RD*WIDTH bits: packed read data.
REQ-009 SHALL have port rd_busy, output, NUM_RD bits: the addressed register has an outstanding write.
REQ-010 SHALL have port wr_en, input, NUM_WR bits: per-port writeback enable.
REQ-011 SHALL have port wr_addr, input, NUM_WR*ADDR_W bits: packed writeback addresses.
REQ-012 SHALL have port wr_data, input, NUM_WR*WIDTH bits: packed writeback data.
REQ-013 SHALL have port iss_en, input, 1 bit: claim a destination register at issue.
REQ-014 SHALL have port iss_addr, input, ADDR_W bits: the destination register being claimed.
REQ-015 SHALL have port iss_ready, output, 1 bit: the claim is acceptable this cycle.
REQ-016 SHALL have port flush, input, 1 bit: clear all pending counts.

Function
REQ-017 SHALL make reads combinational; register 0 SHALL always read 0 and report rd_busy=0.
REQ-018 SHALL update writes on the clock edge; writes to register 0 SHALL be ignored.
REQ-019 SHALL, when several enabled write ports target the same register in one cycle, apply only the highest-numbered port's data.
REQ-020 SHALL keep a 2-bit pending counter per register (maximum 3 outstanding writes).
REQ-021 SHALL drive iss_ready=1 when the counter of iss_addr is below 3, or iss_addr is 0.
REQ-022 SHALL treat iss_en with iss_ready=0 as ignored, with no state change.
REQ-023 SHALL count per register per cycle: next = count + accepted issue (0/1) - number of enabled write ports targeting that register, saturating at 0.
REQ-024 SHALL leave the counter unchanged on a simultaneous issue and single writeback to the same register.
REQ-025 SHALL, on flush, zero all counters next cycle; flush SHALL override any same-cycle issue; same-cycle writes SHALL still update data.
REQ-026 SHALL drive rd_busy[k] = (registered counter of rd_addr[k] != 0), subject to REQ-030.

Reset
REQ-027 SHALL, while rst is high, immediately clear all counters and set all registers to 0, except register 28 = 0x00001800 and register 29 = 0x00002FFE.
REQ-028 SHALL, while rst is high, drive rd_data=0, rd_busy=0 and iss_ready=0; issue and write inputs SHALL be ignored.
REQ-029 SHALL, when rst asserts mid-operation, discard all pending counts; the first edge after release SHALL behave as a normal cycle.

Configuration
REQ-030 SHALL, with macro REGFILE_SB_BYPASS_EN defined, return the same-cycle write data (highest matching port) on a read hitting an enabled write, and compute rd_busy from the counter after that cycle's writebacks; without the macro, reads return stored contents and busy uses only the registered counter.

Structure
REQ-031 SHALL place the reset-value constants for registers 28 and 29, and the counter maximum (3), in shared package regfile_pkg.
REQ-032 SHALL contain one sub-module, regfile_sb_cnt: one 2-bit saturating pending counter with issue/writeback-count/flush inputs, instantiated 2**ADDR_W times.

Verification
REQ-033 SHALL cover reset: assert rst -> reading r28 gives 0x1800, r29 gives 0x2FFE, r5 gives 0; all rd_busy=0; iss_ready=0.
REQ-034 SHALL cover a dual-write conflict: wr_en=2'b11, both ports to r7, data 0xAAAA/0x5555 -> r7 reads 0x5555 next cycle; a write to r0 of 0x1234 -> r0 reads 0.
REQ-035 SHALL cover scoreboard saturation: three issues to r9 -> iss_ready=0 for r9 on the 4th; after one writeback, iss_ready=1 and rd_busy stays 1 until the third writeback.
REQ-036 SHALL cover a simultaneous issue and writeback to r4 with count 1 -> count stays 1; two ports writing back r4 with count 1 -> count 0, no underflow.
REQ-037 SHALL cover bypass: write 0xDEADBEEF to r3 while reading r3 -> with REGFILE_SB_BYPASS_EN the same cycle reads 0xDEADBEEF; without it the old value, and the new value next cycle.
REQ-038 SHALL cover flush: flush with issue to r6 while r2 count is 2 -> all counters 0 next cycle and r6 not busy.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: reset values of the
// stack/frame registers and the pending-counter geometry.
package regfile_pkg;

    localparam int unsigned CNT_W   = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(3);

    localparam int unsigned R28_IDX = 28;
    localparam int unsigned R29_IDX = 29;
    localparam logic [31:0] R28_RST = 32'h0000_1800;
    localparam logic [31:0] R29_RST = 32'h0000_2FFE;

    // Reset contents of register idx.
    function automatic logic [31:0] reg_rst_val(input int unsigned idx);
        case (idx)
            R28_IDX: return R28_RST;
            R29_IDX: return R29_RST;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// One per-register pending-write counter: +1 on accepted issue, minus the
// number of same-cycle writebacks, floored at 0, cleared by flush.
module regfile_sb_cnt
    import regfile_pkg::*;
#(
    parameter int unsigned WB_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss,
    input  logic [WB_W-1:0]  wb_cnt,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned SW = ((WB_W > CNT_W) ? WB_W : CNT_W) + 1;

    logic [SW-1:0]    up;
    logic [SW-1:0]    dn;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin : next_count
        up      = SW'(cnt) + SW'(iss);
        dn      = SW'(wb_cnt);
        cnt_nxt = '0;
        if (!flush && (up > dn)) begin
            cnt_nxt = ((up - dn) > SW'(CNT_MAX)) ? CNT_MAX : CNT_W'(up - dn);
        end
    end

    always_ff @(posedge clk or posedge rst) begin : count_reg
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with a per-register pending-write scoreboard.
// Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle writeback data to reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 4,
    parameter int unsigned NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]  wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     flush
);

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam int unsigned WB_W = $clog2(NUM_WR + 1);

    logic [WIDTH-1:0]  regs   [NREG];
    logic              wr_hit [NREG];
    logic [WIDTH-1:0]  wr_val [NREG];
    logic [WB_W-1:0]   wb_cnt [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic              iss_acc;
    logic [ADDR_W-1:0] ra;

    // Per-register writeback decode; later ports override earlier ones.
    always_comb begin : wb_decode
        for (int unsigned i = 0; i < NREG; i++) begin
            wr_hit[i] = 1'b0;
            wr_val[i] = '0;
            wb_cnt[i] = '0;
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = wr_data[j*WIDTH +: WIDTH];
                    wb_cnt[i] = wb_cnt[i] + WB_W'(1);
                end
            end
        end
        wr_hit[0] = 1'b0;
        wb_cnt[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin : reg_array
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= WIDTH'(reg_rst_val(i));
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (wr_hit[i]) begin
                    regs[i] <= wr_val[i];
                end
            end
        end
    end

    assign iss_ready = !rst && ((iss_addr == '0) || (cnt_q[iss_addr] != CNT_MAX));
    assign iss_acc   = iss_en && iss_ready && (iss_addr != '0);

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        regfile_sb_cnt #(
            .WB_W (WB_W)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .iss    (iss_acc && (iss_addr == ADDR_W'(g))),
            .wb_cnt (wb_cnt[g]),
            .flush  (flush),
            .cnt    (cnt_q[g])
        );
    end

`ifdef REGFILE_SB_BYPASS_EN
    logic [CNT_W-1:0] cnt_wb [NREG];

    // Pending count once this cycle's writebacks have retired.
    always_comb begin : busy_after_wb
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_wb[i] = (int'(cnt_q[i]) > int'(wb_cnt[i]))
                      ? CNT_W'(int'(cnt_q[i]) - int'(wb_cnt[i])) : '0;
        end
    end
`endif

    always_comb begin : read_ports
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (!rst && (ra != '0)) begin
`ifdef REGFILE_SB_BYPASS_EN
                rd_data[k*WIDTH +: WIDTH] = wr_hit[ra] ? wr_val[ra] : regs[ra];
                rd_busy[k]                = (cnt_wb[ra] != '0);
`else
                rd_data[k*WIDTH +: WIDTH] = regs[ra];
                rd_busy[k]                = (cnt_q[ra] != '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*W-1:0]   rd_data;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*W-1:0]   wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              iss_ready;
    logic              flush;

    int n_vec = 0;
    int n_err = 0;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*W +: W]   = d;
    endtask

    function automatic logic [W-1:0] rdv(input int k);
        return rd_data[k*W +: W];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rd_addr = '0;
        idle();
        set_rd(0, 5'd28); set_rd(1, 5'd29); set_rd(2, 5'd5);
        iss_addr = 5'd3;
        #3;
        n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL rst_rd_data got %h want 0", rd_data); end
        n_vec++; if (rd_busy !== 4'b0) begin n_err++; $display("FAIL rst_rd_busy got %b want 0", rd_busy); end
        n_vec++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL rst_iss_ready got %b want 0", iss_ready); end
        tick(); tick();
        #3 rst = 1'b0;
        #1;
        n_vec++; if (rdv(0) !== 32'h0000_1800) begin n_err++; $display("FAIL r28_reset got %h want 00001800", rdv(0)); end
        n_vec++; if (rdv(1) !== 32'h0000_2FFE) begin n_err++; $display("FAIL r29_reset got %h want 00002ffe", rdv(1)); end
        n_vec++; if (rdv(2) !== 32'h0) begin n_err++; $display("FAIL r5_reset got %h want 0", rdv(2)); end
        n_vec++; if (rd_busy !== 4'b0) begin n_err++; $display("FAIL post_rst_busy got %b want 0", rd_busy); end
        n_vec++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_iss_ready got %b want 1", iss_ready); end
    endtask

    task automatic test_dual_write();
        idle();
        set_wr(0, 5'd7, 32'h0000_AAAA);
        set_wr(1, 5'd7, 32'h0000_5555);
        tick();
        idle();
        set_wr(0, 5'd0, 32'h0000_1234);
        tick();
        idle();
        set_rd(0, 5'd7); set_rd(1, 5'd0);
        #1;
        n_vec++; if (rdv(0) !== 32'h0000_5555) begin n_err++; $display("FAIL dual_write_r7 got %h want 00005555", rdv(0)); end
        n_vec++; if (rdv(1) !== 32'h0) begin n_err++; $display("FAIL write_r0 got %h want 0", rdv(1)); end
        n_vec++; if (rd_busy[1:0] !== 2'b00) begin n_err++; $display("FAIL dual_write_busy got %b want 00", rd_busy[1:0]); end
    endtask

    task automatic test_saturation();
        idle();
        set_rd(0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            iss_en = 1'b1; iss_addr = 5'd9;
            #1;
            n_vec++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL sat_ready_%0d got %b want 1", i, iss_ready); end
            tick();
        end
        iss_en = 1'b1; iss_addr = 5'd9;
        #1;
        n_vec++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL sat_ready_4th got %b want 0", iss_ready); end
        tick();
        idle();
        #1;
        n_vec++; if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL sat_busy got %b want 1", rd_busy[0]); end
        iss_addr = 5'd9;
        #1;
        n_vec++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL sat_ignored_issue got %b want 0", iss_ready); end
        for (int i = 0; i < 3; i++) begin
            idle();
            set_wr(0, 5'd9, 32'(i + 1));
            tick();
            idle();
            iss_addr = 5'd9;
            #1;
            n_vec++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL sat_wb%0d_ready got %b want 1", i, iss_ready); end
            n_vec++; if (rd_busy[0] !== (i < 2)) begin n_err++; $display("FAIL sat_wb%0d_busy got %b want %b", i, rd_busy[0], (i < 2)); end
        end
        n_vec++; if (rdv(0) !== 32'd3) begin n_err++; $display("FAIL sat_r9_data got %h want 3", rdv(0)); end
    endtask

    task automatic test_issue_wb_same();
        idle();
        set_rd(0, 5'd4);
        iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        idle();
        iss_en = 1'b1; iss_addr = 5'd4;
        set_wr(0, 5'd4, 32'h44);
        tick();
        idle();
        #1;
        n_vec++; if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL iss_wb_same_busy got %b want 1", rd_busy[0]); end
        set_wr(0, 5'd4, 32'h45);
        set_wr(1, 5'd4, 32'h46);
        tick();
        idle();
        #1;
        n_vec++; if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL double_wb_busy got %b want 0", rd_busy[0]); end
        n_vec++; if (rdv(0) !== 32'h46) begin n_err++; $display("FAIL double_wb_data got %h want 46", rdv(0)); end
        // An underflowed counter would read 3 and refuse the first issue.
        for (int i = 0; i < 3; i++) begin
            iss_en = 1'b1; iss_addr = 5'd4;
            #1;
            n_vec++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL no_underflow_ready_%0d got %b want 1", i, iss_ready); end
            tick();
        end
        iss_en = 1'b0;
        #1;
        n_vec++; if (iss_ready !== 1'b0) begin n_err++; $display("FAIL r4_full got %b want 0", iss_ready); end
        idle();
    endtask

    task automatic test_bypass();
        idle();
        set_rd(0, 5'd3);
        set_wr(1, 5'd3, 32'hDEAD_BEEF);
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        n_vec++; if (rdv(0) !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bypass_same_cycle got %h want deadbeef", rdv(0)); end
`else
        n_vec++; if (rdv(0) !== 32'h0) begin n_err++; $display("FAIL nobypass_same_cycle got %h want 0", rdv(0)); end
`endif
        tick();
        idle();
        #1;
        n_vec++; if (rdv(0) !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bypass_next_cycle got %h want deadbeef", rdv(0)); end
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 2; i++) begin
            iss_en = 1'b1; iss_addr = 5'd2;
            tick();
        end
        idle();
        set_rd(0, 5'd2); set_rd(1, 5'd6); set_rd(2, 5'd4); set_rd(3, 5'd11);
        #1;
        n_vec++; if (rd_busy !== 4'b0101) begin n_err++; $display("FAIL pre_flush_busy got %b want 0101", rd_busy); end
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
        set_wr(0, 5'd11, 32'h00C0_FFEE);
        tick();
        idle();
        iss_addr = 5'd4;
        #1;
        n_vec++; if (rd_busy !== 4'b0000) begin n_err++; $display("FAIL flush_busy got %b want 0000", rd_busy); end
        n_vec++; if (iss_ready !== 1'b1) begin n_err++; $display("FAIL flush_r4_ready got %b want 1", iss_ready); end
        n_vec++; if (rdv(3) !== 32'h00C0_FFEE) begin n_err++; $display("FAIL flush_write_r11 got %h want 00c0ffee", rdv(3)); end
    endtask

    task automatic test_read_ports();
        idle();
        set_rd(0, 5'd7); set_rd(1, 5'd3); set_rd(2, 5'd29); set_rd(3, 5'd0);
        #1;
        n_vec++; if (rd_data !== {32'h0, 32'h0000_2FFE, 32'hDEAD_BEEF, 32'h0000_5555}) begin
            n_err++; $display("FAIL four_port_read got %h", rd_data);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        set_wr(0, 5'd10, 32'h77);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            iss_en = 1'b1; iss_addr = 5'd10;
            tick();
        end
        idle();
        set_rd(0, 5'd10); set_rd(1, 5'd12); set_rd(2, 5'd28); set_rd(3, 5'd13);
        #1;
        n_vec++; if (rd_busy[0] !== 1'b1 || rdv(0) !== 32'h77) begin
            n_err++; $display("FAIL pre_rst_r10 got busy=%b data=%h want 1/77", rd_busy[0], rdv(0));
        end
        #1 rst = 1'b1;
        iss_en = 1'b1; iss_addr = 5'd13;
        set_wr(0, 5'd12, 32'h1212);
        #1;
        n_vec++; if (rd_busy !== 4'b0 || rd_data !== '0 || iss_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_outputs got busy=%b data=%h ready=%b want 0", rd_busy, rd_data, iss_ready);
        end
        tick(); tick();
        idle();
        rst = 1'b0;
        #1;
        n_vec++; if (rd_busy !== 4'b0) begin n_err++; $display("FAIL post_mid_rst_busy got %b want 0", rd_busy); end
        n_vec++; if (rdv(0) !== 32'h0 || rdv(1) !== 32'h0) begin
            n_err++; $display("FAIL post_mid_rst_data got r10=%h r12=%h want 0", rdv(0), rdv(1));
        end
        n_vec++; if (rdv(2) !== 32'h0000_1800) begin n_err++; $display("FAIL post_mid_rst_r28 got %h want 00001800", rdv(2)); end
        set_wr(0, 5'd10, 32'h99);
        iss_en = 1'b1; iss_addr = 5'd13;
        tick();
        idle();
        #1;
        n_vec++; if (rdv(0) !== 32'h99) begin n_err++; $display("FAIL first_edge_write got %h want 99", rdv(0)); end
        n_vec++; if (rd_busy !== 4'b1000) begin n_err++; $display("FAIL first_edge_issue got %b want 1000", rd_busy); end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_saturation();
        test_issue_wb_same();
        test_bypass();
        test_flush();
        test_read_ports();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
